mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences shared access to the main-memory port between N requesters (instruction-fetch cache, data cache, and any later master such as a debug loader). It owns one outstanding transaction at a time and holds the grant until the memory side reports completion. Priority is fixed in favour of one requester, with starvation protection, and ties fall back to round-robin. It replaces ad-hoc muxing in front of the bulk-read-to-AXI adapter.

## Interface
- NUM_REQ, 2, number of requesters (≥2); ID_W = $clog2(NUM_REQ)
- ADDR_W, 64, request address width
- PRIO_IDX, 1, requester given fixed priority (data cache)
- STARVE_LIMIT, 4, grants lost before a requester is force-served (≥1)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; held until matching req_ready
- req_addr  in  NUM_REQ×ADDR_W  per-requester address, stable while req_valid
- req_is_write  in  NUM_REQ  per-requester direction, stable while req_valid
- req_ready  out  NUM_REQ  one-cycle accept pulse to granted requester
- req_done  out  NUM_REQ  one-cycle completion pulse to granted requester
- mem_valid  out  1  request to memory port
- mem_addr  out  ADDR_W  address of granted requester
- mem_is_write  out  1  direction of granted requester
- mem_ready  in  1  memory port accepts request
- mem_done  in  1  memory port finished transaction (last beat / write response)
- grant_id  out  ID_W  current owner; data/beat steering uses this
- busy  out  1  high outside IDLE

## Operation
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE: if any req_valid, select winner, register grant_id, go to ISSUE. Otherwise stay.
- Winner selection, in order:
  - Lowest-index requester with starve_cnt == STARVE_LIMIT and req_valid.
  - Else PRIO_IDX if valid.
  - Else first valid requester scanning from last_grant+1 upward, mod NUM_REQ.
- ISSUE: mem_valid=1; mem_addr/mem_is_write = req_addr/req_is_write[grant_id] (combinational from the held inputs). When mem_ready is high, req_ready[grant_id]=mem_ready (combinational) and the block goes to WAIT_DONE.
- WAIT_DONE: req_done[grant_id]=mem_done (combinational). On mem_done, go to IDLE.
- mem_done while in ISSUE or IDLE is ignored.
- Starvation counters (per requester, width $clog2(STARVE_LIMIT+1)):
  - Updated on the IDLE→ISSUE transition.
  - Winner clears to 0.
  - Every other requester with req_valid increments, saturating at STARVE_LIMIT.
  - Non-requesting requesters hold their value.
- last_grant is updated to the winner on every grant, whichever rule picked it.
- A requester deasserting req_valid before req_ready is a protocol violation. Behaviour is then unspecified; the bench asserts against it.
- Reset (asynchronous, any state, including mid-transaction): state=IDLE, grant_id=0, last_grant=NUM_REQ-1, all starve_cnt=0. The in-flight transaction is abandoned; no req_done is issued.

## Timing
- Reset values: mem_valid=0, req_ready=0, req_done=0, busy=0, grant_id=0, mem_addr=req_addr[0], mem_is_write=req_is_write[0].
- Arbitration latency: request seen in IDLE at cycle T gives mem_valid=1 at T+1.
- Accept: req_ready pulses in the same cycle as the mem_valid&&mem_ready handshake.
- Completion: req_done pulses in the same cycle as mem_done. State is IDLE at the next cycle; a new grant can issue at the cycle after that.
- Minimum per-transaction occupancy is 3 cycles: IDLE, ISSUE, then WAIT_DONE with an immediate mem_done.
- Never more than one req_ready or req_done bit high in a cycle.
- grant_id is stable from ISSUE entry until return to IDLE.

## Test plan
- Single requester: req_valid[0]=1, addr 0x1000, read; mem_ready at cycle 3, mem_done at cycle 6. Required: mem_valid cycles 1–3, req_ready[0] at cycle 3, req_done[0] at cycle 6, busy low at cycle 7.
- Simultaneous requests, both held continuously, PRIO_IDX=1, STARVE_LIMIT=4, immediate ready/done. Required grant sequence 1,1,1,1,0,1,1,1,1,0; starve_cnt[0] reaches 4 before each grant to 0.
- PRIO_IDX not requesting, NUM_REQ=3, requesters 0 and 2 held, last_grant=0. Required: round-robin grants 2,0,2,0.
- Backpressure: mem_ready low for 10 cycles. Required: mem_valid, mem_addr and grant_id stable throughout, no req_ready until mem_ready rises.
- Spurious mem_done in ISSUE (before mem_ready). Required: ignored, no req_done, state stays ISSUE.
- Async rst asserted mid-WAIT_DONE, between clock edges. Required: mem_valid=0 and busy=0 immediately, no req_done; first grant after release honours PRIO_IDX with all starve counters 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared memory port.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]             req_is_write;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_done;
  logic                           mem_valid;
  logic [ADDR_W-1:0]              mem_addr;
  logic                           mem_is_write;
  logic                           mem_ready;
  logic                           mem_done;
  logic [ID_W-1:0]                grant_id;
  logic                           busy;

  modport slave (
    input  req_valid, req_addr, req_is_write, mem_ready, mem_done,
    output req_ready, req_done, mem_valid, mem_addr, mem_is_write, grant_id, busy
  );

  modport master (
    output req_valid, req_addr, req_is_write, mem_ready, mem_done,
    input  req_ready, req_done, mem_valid, mem_addr, mem_is_write, grant_id, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the main-memory port: starvation-protected fixed
// priority with round-robin fallback; the grant is held until the memory side completes.
//
// state     | meaning
// S_IDLE    | no owner; arbitrate among valid requesters
// S_ISSUE   | request presented to memory, waiting for mem_ready
// S_WAIT    | accepted by memory, waiting for mem_done
module mem_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 64,
  parameter int PRIO_IDX     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] starve_q [NUM_REQ];
  logic [CNT_W-1:0] starve_d [NUM_REQ];

  logic             any_req;
  logic             starve_hit;
  logic [ID_W-1:0]  starve_id;
  logic [ID_W-1:0]  rr_id;
  logic [ID_W-1:0]  win_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      last_q   <= ID_W'(NUM_REQ - 1);
      starve_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      starve_q <= starve_d;
    end
  end

  // Descending scans let the lowest matching index overwrite earlier hits.
  always_comb begin
    int j;
    any_req    = |bus.req_valid;
    starve_hit = 1'b0;
    starve_id  = '0;
    rr_id      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (starve_q[i] == CNT_W'(STARVE_LIMIT))) begin
        starve_hit = 1'b1;
        starve_id  = ID_W'(i);
      end
    end
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = int'(last_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (bus.req_valid[j]) rr_id = ID_W'(j);
    end
    if (starve_hit)                  win_id = starve_id;
    else if (bus.req_valid[PRIO_IDX]) win_id = ID_W'(PRIO_IDX);
    else                             win_id = rr_id;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ISSUE;
          grant_d = win_id;
          last_d  = win_id;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_id)
              starve_d[i] = '0;
            else if (bus.req_valid[i] && (starve_q[i] != CNT_W'(STARVE_LIMIT)))
              starve_d[i] = starve_q[i] + CNT_W'(1);
          end
        end
      end
      S_ISSUE: if (bus.mem_ready) state_d = S_WAIT;
      S_WAIT:  if (bus.mem_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = '0;
    bus.req_done     = '0;
    bus.mem_valid    = (state_q == S_ISSUE);
    bus.busy         = (state_q != S_IDLE);
    bus.grant_id     = grant_q;
    bus.mem_addr     = bus.req_addr[grant_q];
    bus.mem_is_write = bus.req_is_write[grant_q];
    if (state_q == S_ISSUE && bus.mem_ready) bus.req_ready[grant_q] = 1'b1;
    if (state_q == S_WAIT  && bus.mem_done)  bus.req_done[grant_q]  = 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level
// arbitration model (3 requesters, data-cache priority on index 1).
module tb_mem_port_arbiter;
  localparam int N     = 3;
  localparam int AW    = 64;
  localparam int PRIO  = 1;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW)) bus ();

  mem_port_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .PRIO_IDX(PRIO), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int m_cnt [N];
  int m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.mem_ready = 1'b0;
    bus.mem_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_last = N - 1;
  endtask

  // Arbitration rules applied to a set of valid requesters; updates the model.
  function automatic int model_grant(input logic [N-1:0] v);
    int w;
    w = -1;
    for (int i = 0; i < N; i++)
      if (w < 0 && v[i] && m_cnt[i] == LIMIT) w = i;
    if (w < 0 && v[PRIO]) w = PRIO;
    for (int k = 1; k <= N; k++)
      if (w < 0 && v[(m_last + k) % N]) w = (m_last + k) % N;
    for (int i = 0; i < N; i++) begin
      if (i == w) m_cnt[i] = 0;
      else if (v[i] && m_cnt[i] < LIMIT) m_cnt[i] = m_cnt[i] + 1;
    end
    m_last = w;
    return w;
  endfunction

  // One transaction with immediate ready/done; starts in an IDLE cycle with requests held.
  task automatic txn_fast(input int exp_id, input string tag);
    logic [N-1:0] one;
    one = N'(1) << exp_id;
    step();
    bus.mem_ready = 1'b1;
    #1;
    chk({tag, "_grant"}, 64'(bus.grant_id), 64'(exp_id));
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'(one));
    step();
    bus.mem_ready = 1'b0;
    bus.mem_done  = 1'b1;
    #1;
    chk({tag, "_done"}, 64'(bus.req_done), 64'(one));
    step();
    bus.mem_done = 1'b0;
    #1;
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  logic [N-1:0] prev_v, prev_r;
  logic         prev_rst = 1'b1;
  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      chk("proto_hold", 64'((prev_v & ~prev_r & ~bus.req_valid) == '0), 64'd1);
      chk("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
      chk("done_onehot0", 64'($onehot0(bus.req_done)), 64'd1);
    end
    prev_v   <= bus.req_valid;
    prev_r   <= bus.req_ready;
    prev_rst <= rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]  pend;
    logic [AW-1:0] a [N];
    logic          wr [N];
    int            seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int            w, d, e;

    bus.req_valid    = '0;
    bus.req_addr[0]  = 64'h1000;
    bus.req_addr[1]  = 64'h2000;
    bus.req_addr[2]  = 64'h3000;
    bus.req_is_write = 3'b001;
    bus.mem_ready    = 1'b0;
    bus.mem_done     = 1'b0;

    // Reset values while rst is held
    #2;
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_req_done",  64'(bus.req_done),  64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_grant",     64'(bus.grant_id),  64'd0);
    chk("rst_mem_addr",  64'(bus.mem_addr),  64'h1000);
    chk("rst_mem_wr",    64'(bus.mem_is_write), 64'd1);

    // Single requester, read of 0x1000: ready at cycle 3, done at cycle 6
    do_reset();
    bus.req_is_write = 3'b000;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) step();
      bus.req_valid[0] = (c <= 3);
      bus.mem_ready    = (c == 3);
      bus.mem_done     = (c == 6);
      #1;
      chk($sformatf("single_mvalid_c%0d", c), 64'(bus.mem_valid), 64'(c >= 1 && c <= 3));
      chk($sformatf("single_ready_c%0d", c), 64'(bus.req_ready), (c == 3) ? 64'd1 : 64'd0);
      chk($sformatf("single_done_c%0d", c), 64'(bus.req_done), (c == 6) ? 64'd1 : 64'd0);
      chk($sformatf("single_busy_c%0d", c), 64'(bus.busy), 64'(c >= 1 && c <= 6));
      if (c == 1) begin
        chk("single_addr", 64'(bus.mem_addr), 64'h1000);
        chk("single_wr", 64'(bus.mem_is_write), 64'd0);
      end
    end
    bus.mem_done = 1'b0;

    // Starvation: requesters 0 and 1 held continuously
    do_reset();
    bus.req_valid = 3'b011;
    for (int k = 0; k < 10; k++) begin
      if (seq[k] == 0) chk($sformatf("starve_cnt0_k%0d", k), 64'(dut.starve_q[0]), 64'd4);
      txn_fast(seq[k], $sformatf("starve_k%0d", k));
    end
    for (int k = 0; k < 3; k++) txn_fast(1, $sformatf("pre_rst_k%0d", k));

    // Async reset in the middle of WAIT_DONE, between clock edges
    step();
    bus.mem_ready = 1'b1;
    #1;
    chk("pre_rst_grant", 64'(bus.grant_id), 64'd1);
    step();
    bus.mem_ready = 1'b0;
    #1;
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    chk("pre_rst_cnt0", 64'(dut.starve_q[0]), 64'd4);
    #2;
    rst = 1'b1;
    bus.mem_done = 1'b1;
    #1;
    chk("arst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("arst_busy",      64'(bus.busy),      64'd0);
    chk("arst_done",      64'(bus.req_done),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_done = 1'b0;
    #1;
    chk("arst_cnt0", 64'(dut.starve_q[0]), 64'd0);
    txn_fast(1, "post_rst");

    // Round-robin without the priority requester: last_grant=0, then 0 and 2 held
    do_reset();
    bus.req_valid = 3'b001;
    txn_fast(0, "rr_seed");
    bus.req_valid = 3'b101;
    txn_fast(2, "rr0");
    txn_fast(0, "rr1");
    txn_fast(2, "rr2");
    txn_fast(0, "rr3");

    // Backpressure for 10 cycles with a spurious mem_done in ISSUE
    do_reset();
    bus.req_addr[2]     = 64'hDEAD_BEEF_0000_1234;
    bus.req_is_write[2] = 1'b1;
    bus.req_valid       = 3'b100;
    step();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      bus.mem_ready = 1'b0;
      bus.mem_done  = (c == 4);
      #1;
      chk($sformatf("bp_mvalid_c%0d", c), 64'(bus.mem_valid), 64'd1);
      chk($sformatf("bp_addr_c%0d", c), 64'(bus.mem_addr), 64'hDEAD_BEEF_0000_1234);
      chk($sformatf("bp_wr_c%0d", c), 64'(bus.mem_is_write), 64'd1);
      chk($sformatf("bp_grant_c%0d", c), 64'(bus.grant_id), 64'd2);
      chk($sformatf("bp_ready_c%0d", c), 64'(bus.req_ready), 64'd0);
      chk($sformatf("bp_done_c%0d", c), 64'(bus.req_done), 64'd0);
    end
    step();
    bus.mem_done  = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("bp_ready_rise", 64'(bus.req_ready), 64'd4);
    step();
    bus.mem_ready    = 1'b0;
    bus.req_valid[2] = 1'b0;
    #1;
    chk("bp_wait_busy", 64'(bus.busy), 64'd1);
    chk("bp_wait_mvalid", 64'(bus.mem_valid), 64'd0);
    chk("bp_wait_done", 64'(bus.req_done), 64'd0);
    step();
    bus.mem_done = 1'b1;
    #1;
    chk("bp_done", 64'(bus.req_done), 64'd4);
    step();
    bus.mem_done = 1'b0;
    #1;
    chk("bp_idle", 64'(bus.busy), 64'd0);

    // Randomized traffic against the arbitration model
    do_reset();
    pend = '0;
    for (int t = 0; t < 80; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          a[i]    = {$urandom, $urandom};
          wr[i]   = 1'($urandom_range(0, 1));
          bus.req_addr[i]     = a[i];
          bus.req_is_write[i] = wr[i];
        end
      end
      bus.req_valid = pend;
      if (pend == '0) begin
        step();
        chk($sformatf("rnd%0d_idle_busy", t), 64'(bus.busy), 64'd0);
        continue;
      end
      w = model_grant(pend);
      d = $urandom_range(0, 3);
      e = $urandom_range(0, 3);
      for (int c = 0; c <= d; c++) begin
        step();
        bus.mem_ready = (c == d);
        bus.mem_done  = (c < d) ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        chk($sformatf("rnd%0d_grant", t), 64'(bus.grant_id), 64'(w));
        chk($sformatf("rnd%0d_addr", t), 64'(bus.mem_addr), 64'(a[w]));
        chk($sformatf("rnd%0d_wr", t), 64'(bus.mem_is_write), 64'(wr[w]));
        chk($sformatf("rnd%0d_mvalid", t), 64'(bus.mem_valid), 64'd1);
        chk($sformatf("rnd%0d_ready", t), 64'(bus.req_ready),
            (c == d) ? 64'(N'(1) << w) : 64'd0);
        chk($sformatf("rnd%0d_issue_done", t), 64'(bus.req_done), 64'd0);
      end
      for (int c = 0; c <= e; c++) begin
        step();
        if (c == 0) begin
          bus.mem_ready = 1'b0;
          pend[w]       = 1'b0;
          bus.req_valid = pend;
        end
        bus.mem_done = (c == e);
        #1;
        chk($sformatf("rnd%0d_done", t), 64'(bus.req_done),
            (c == e) ? 64'(N'(1) << w) : 64'd0);
        chk($sformatf("rnd%0d_wait_busy", t), 64'(bus.busy), 64'd1);
        chk($sformatf("rnd%0d_wait_mvalid", t), 64'(bus.mem_valid), 64'd0);
      end
      step();
      bus.mem_done = 1'b0;
      #1;
      chk($sformatf("rnd%0d_back_idle", t), 64'(bus.busy), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
